// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: shared op encodings, FSM states and datapath width for logic_op_arbiter.
`default_nettype none

package logic_arb_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/and_64bit.sv
// and_64bit: 64 independent two-input AND gates.
`default_nettype none

module and_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    and u_gate (y[i], a[i], b[i]);
  end

endmodule

`default_nettype wire

// File: rtl/logic_unit_64.sv
// logic_unit_64: combinational AND/OR/XOR unit built from the gate-level 64-bit cells; reserved op yields 0.
`default_nettype none

module logic_unit_64
  import logic_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] and_y;
  logic [DATA_W-1:0] or_y;
  logic [DATA_W-1:0] xor_y;

  and_64bit u_and (.a(a), .b(b), .y(and_y));
  or_64bit  u_or  (.a(a), .b(b), .y(or_y));
  xor_64bit u_xor (.a(a), .b(b), .y(xor_y));

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/or_64bit.sv
// or_64bit: 64 independent two-input OR gates.
`default_nettype none

module or_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    or u_gate (y[i], a[i], b[i]);
  end

endmodule

`default_nettype wire

// File: rtl/xor_64bit.sv
// xor_64bit: 64 independent two-input XOR gates.
`default_nettype none

module xor_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    xor u_gate (y[i], a[i], b[i]);
  end

endmodule

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin sharing of one 64-bit logic unit among NUM_REQ requesters.
// Optional macro LOGIC_ARB_ERR_EN adds the rsp_err output flagging the reserved op.
`default_nettype none

module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
`ifdef LOGIC_ARB_ERR_EN
  output logic                      rsp_err,
`endif
  output logic                      busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] unit_y;

  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];
  logic [1:0]        op_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
    assign op_arr[i] = req_op[i*2 +: 2];
  end

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found && !reset) begin
          req_ready[pick] = 1'b1;
          state_nxt       = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic_unit_64 u_unit (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (unit_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      rsp_data <= '0;
      rsp_id   <= '0;
`ifdef LOGIC_ARB_ERR_EN
      rsp_err  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            a_q   <= a_arr[pick];
            b_q   <= b_arr[pick];
            op_q  <= op_arr[pick];
            grant <= pick;
          end
        end
        EXEC: begin
          rsp_data <= unit_y;
          rsp_id   <= grant;
`ifdef LOGIC_ARB_ERR_EN
          rsp_err  <= (op_q == OP_RSVD);
`endif
        end
        RESP: begin
          // Pointer moves only when the response completes, not on accept.
          if (rsp_ready) begin
            rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state == EXEC) || (state == RESP);

endmodule

`default_nettype wire
